// File: rtl/demultiplexer_bus_16_buffered_pkg.sv
// Shared constants and helpers for the 16-way buffered bus demultiplexer.
package demux_pkg;

  localparam int DEMUX_CHANNELS = 16;
  localparam int DEMUX_SEL_W    = 4;

  // Low bit of channel k inside the flattened 16*width output bus.
  function automatic int slice_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/demultiplexer_bus_16_buffered_if.sv
// Bus bundle between the shared input port and the 16 channel consumers.
interface demultiplexer_bus_16_buffered_if
  import demux_pkg::*;
#(
  parameter int nrOfBits = 1
);
  logic                               enable;
  logic                               flush;
  logic [DEMUX_SEL_W-1:0]             sel;
  logic [nrOfBits-1:0]                demuxIn;
  logic                               in_valid;
  logic                               in_ready;
  logic [DEMUX_CHANNELS*nrOfBits-1:0] demuxOut;
  logic [DEMUX_CHANNELS-1:0]          out_valid;
  logic [DEMUX_CHANNELS-1:0]          out_ready;
  logic                               busy;

  modport master (
    output enable, flush, sel, demuxIn, in_valid, out_ready,
    input  in_ready, demuxOut, out_valid, busy
  );

  modport slave (
    input  enable, flush, sel, demuxIn, in_valid, out_ready,
    output in_ready, demuxOut, out_valid, busy
  );
endinterface

// File: rtl/demultiplexer_bus_16_buffered_channel_slot.sv
// One-entry holding register for a single demux output channel.
module demux_channel_slot #(
  parameter int nrOfBits = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic                drain,
  input  logic                flush,
  input  logic [nrOfBits-1:0] din,
  output logic                valid,
  output logic [nrOfBits-1:0] dout
);

  logic                valid_d, valid_q;
  logic [nrOfBits-1:0] data_d,  data_q;

  // Load wins over drain so a simultaneous take-and-refill keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/demultiplexer_bus_16_buffered.sv
// Registered 1-to-16 bus demultiplexer; each channel buffers one word with its
// own valid/ready handshake so a stalled consumer only blocks its own traffic.
module demultiplexer_bus_16_buffered
  import demux_pkg::*;
#(
  parameter int nrOfBits = 1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  demultiplexer_bus_16_buffered_if.slave  bus
);

  logic                               accept;
  logic [DEMUX_CHANNELS-1:0]          load_vec;
  logic [DEMUX_CHANNELS-1:0]          drain_vec;
  logic [DEMUX_CHANNELS-1:0]          valid_vec;
  logic [DEMUX_CHANNELS*nrOfBits-1:0] data_flat;
  logic                               in_ready;

  // Ready looks through to the selected consumer, giving full throughput.
  assign in_ready = bus.enable & ~bus.flush
                  & (~valid_vec[bus.sel] | bus.out_ready[bus.sel]);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    load_vec  = '0;
    drain_vec = '0;
    for (int k = 0; k < DEMUX_CHANNELS; k++) begin
      load_vec[k]  = accept && (bus.sel == DEMUX_SEL_W'(k));
      drain_vec[k] = valid_vec[k] & bus.out_ready[k];
    end
  end

  for (genvar k = 0; k < DEMUX_CHANNELS; k++) begin : g_slot
    localparam int LO = slice_lo(k, nrOfBits);

    demux_channel_slot #(
      .nrOfBits (nrOfBits)
    ) u_slot (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (load_vec[k]),
      .drain   (drain_vec[k]),
      .flush   (bus.flush),
      .din     (bus.demuxIn),
      .valid   (valid_vec[k]),
      .dout    (data_flat[LO +: nrOfBits])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_vec;
  assign bus.demuxOut  = data_flat;
  assign bus.busy      = |valid_vec;

endmodule

// File: tb/tb_demultiplexer_bus_16_buffered.sv
// Directed self-checking bench for the 16-way buffered demultiplexer (8-bit words).
module tb_demultiplexer_bus_16_buffered;

  localparam int W = 8;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  demultiplexer_bus_16_buffered_if #(.nrOfBits(W)) bus ();

  demultiplexer_bus_16_buffered #(.nrOfBits(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] slice(input int k);
    logic [16*W-1:0] flat;
    flat = bus.demuxOut;
    return flat[k*W +: W];
  endfunction

  task automatic idle_inputs();
    bus.enable    = 1'b1;
    bus.flush     = 1'b0;
    bus.sel       = 4'd0;
    bus.demuxIn   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 16'h0000;
  endtask

  task automatic send(input logic [3:0] s, input logic [W-1:0] d);
    bus.sel      = s;
    bus.demuxIn  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_all();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    checks++;
    if (bus.out_valid !== 16'h0000) begin
      failures++;
      $display("FAIL reset_out_valid: got %h expected 0000", bus.out_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.demuxOut !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", bus.demuxOut);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_routing();
    bus.out_ready = 16'h0000;
    bus.sel = 4'd3; bus.demuxIn = 8'hA5; bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_ready3: got %b expected 1", bus.in_ready);
    end
    tick();
    bus.sel = 4'd15; bus.demuxIn = 8'h3C;
    checks++;
    if (bus.out_valid !== 16'h0008 || slice(3) !== 8'hA5) begin
      failures++;
      $display("FAIL basic_first: got valid=%h s3=%h expected valid=0008 s3=a5",
               bus.out_valid, slice(3));
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 16'h8008 || slice(15) !== 8'h3C || slice(3) !== 8'hA5) begin
      failures++;
      $display("FAIL basic_second: got valid=%h s3=%h s15=%h expected valid=8008 s3=a5 s15=3c",
               bus.out_valid, slice(3), slice(15));
    end
    bus.sel = 4'd3; bus.demuxIn = 8'h77; bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_full_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 16'h8008 || slice(3) !== 8'hA5 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_no_overwrite: got valid=%h s3=%h busy=%b expected 8008 a5 1",
               bus.out_valid, slice(3), bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 16'h0080;
    for (int i = 1; i <= 16; i++) begin
      bus.sel = 4'd7; bus.demuxIn = W'(i); bus.in_valid = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready word %0d: got %b expected 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid[7] !== 1'b1 || slice(7) !== W'(i)) begin
        failures++;
        $display("FAIL b2b_data word %0d: got v=%b d=%h expected v=1 d=%h",
                 i, bus.out_valid[7], slice(7), W'(i));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 16'h8008) begin
      failures++;
      $display("FAIL b2b_drained: got %h expected 8008", bus.out_valid);
    end
    bus.out_ready = 16'h0000;
  endtask

  task automatic test_stall();
    clear_all();
    send(4'd2, 8'h22);
    bus.sel = 4'd2; bus.demuxIn = 8'h55; bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_ready2: got %b expected 0", bus.in_ready);
    end
    bus.sel = 4'd9; bus.demuxIn = 8'h99;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_ready9: got %b expected 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 16'h0204 || slice(9) !== 8'h99 || slice(2) !== 8'h22) begin
      failures++;
      $display("FAIL stall_bypass: got valid=%h s9=%h s2=%h expected 0204 99 22",
               bus.out_valid, slice(9), slice(2));
    end
    bus.sel = 4'd2; bus.demuxIn = 8'h55; bus.out_ready = 16'h0004;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready: got %b expected 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 16'h0000;
    checks++;
    if (bus.out_valid !== 16'h0204 || slice(2) !== 8'h55) begin
      failures++;
      $display("FAIL stall_refill: got valid=%h s2=%h expected 0204 55",
               bus.out_valid, slice(2));
    end
  endtask

  task automatic test_enable();
    clear_all();
    checks++;
    if (bus.out_valid !== 16'h0000 || slice(2) !== 8'h55) begin
      failures++;
      $display("FAIL flush_keeps_data: got valid=%h s2=%h expected 0000 55",
               bus.out_valid, slice(2));
    end
    send(4'd0, 8'h10);
    send(4'd5, 8'h50);
    bus.enable = 1'b0; bus.sel = 4'd6; bus.demuxIn = 8'h66; bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL enable_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 16'h0021) begin
      failures++;
      $display("FAIL enable_no_accept: got %h expected 0021", bus.out_valid);
    end
    bus.out_ready = 16'h0021;
    tick();
    checks++;
    if (bus.out_valid !== 16'h0000 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL enable_drain: got valid=%h busy=%b expected 0000 0",
               bus.out_valid, bus.busy);
    end
    bus.in_valid = 1'b0; bus.out_ready = 16'h0000; bus.enable = 1'b1;
  endtask

  task automatic test_flush();
    send(4'd1, 8'h11);
    send(4'd4, 8'h44);
    bus.flush = 1'b1; bus.sel = 4'd4; bus.demuxIn = 8'hEE; bus.in_valid = 1'b1;
    bus.out_ready = 16'h0010;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 16'h0000;
    checks++;
    if (bus.out_valid !== 16'h0000 || bus.busy !== 1'b0 || slice(4) !== 8'h44) begin
      failures++;
      $display("FAIL flush_clear: got valid=%h busy=%b s4=%h expected 0000 0 44",
               bus.out_valid, bus.busy, slice(4));
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 16; k++) send(4'(k), 8'hE0 + 8'(k));
    checks++;
    if (bus.out_valid !== 16'hFFFF || bus.busy !== 1'b1 || slice(13) !== 8'hED) begin
      failures++;
      $display("FAIL mid_full: got valid=%h busy=%b s13=%h expected ffff 1 ed",
               bus.out_valid, bus.busy, slice(13));
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 16'h0000 || bus.busy !== 1'b0 || bus.demuxOut !== '0) begin
      failures++;
      $display("FAIL mid_async_reset: got valid=%h busy=%b data=%h expected 0000 0 0",
               bus.out_valid, bus.busy, bus.demuxOut);
    end
    tick();
    reset_n = 1'b1;
    send(4'd6, 8'h5A);
    checks++;
    if (bus.out_valid !== 16'h0040 || slice(6) !== 8'h5A) begin
      failures++;
      $display("FAIL mid_after_reset: got valid=%h s6=%h expected 0040 5a",
               bus.out_valid, slice(6));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_routing();
    test_back_to_back();
    test_stall();
    test_enable();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
